// File: rtl/fun_sched_pkg.sv
// Shared definitions for the fun_sched round-robin scheduler.
// Optional watchdog is enabled by defining FUN_SCHED_WATCHDOG_EN.
package fun_sched_pkg;

    localparam int OP_W            = 8;
    localparam int TIMEOUT_DEFAULT = 255;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_ACK,
        ST_RUN,
        ST_DONE
    } state_t;

    // Increment modulo n; n need not be a power of two.
    function automatic int wrap_inc(input int v, input int n);
        return (v + 1 >= n) ? 0 : v + 1;
    endfunction

endpackage

// File: rtl/fun_sched_rr_arbiter.sv
// Combinational round-robin pick: the first set request at or after ptr
// (wrapping modulo N_REQ) wins. Produces a one-hot grant and its index.
module rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int ID_W  = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  ptr,
    output logic [N_REQ-1:0] gnt,
    output logic [ID_W-1:0]  idx,
    output logic             any
);

    // Requester index at offset off from base, wrapped into 0..N_REQ-1.
    function automatic logic [ID_W-1:0] rot(input logic [ID_W-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= N_REQ) s = s - N_REQ;
        return ID_W'(s);
    endfunction

    // Scan from ptr and keep only the first requester found.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first,
        // so no path leaves it unassigned and no latch is inferred.
        gnt = '0;
        idx = '0;
        any = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (!any && req[rot(ptr, i)]) begin
                any           = 1'b1;
                idx           = rot(ptr, i);
                gnt[rot(ptr, i)] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fun_sched.sv
// Round-robin scheduler sharing one multi-cycle fun unit between N_REQ
// requesters. Arbitrates in IDLE, latches the winner's operands, runs the
// unit through start/busy and returns the result tagged with the winner id.
// Define FUN_SCHED_WATCHDOG_EN to build the ACK/RUN timeout watchdog.
module fun_sched
    import fun_sched_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int ID_W    = $clog2(N_REQ),
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [N_REQ-1:0]       req_i,
    input  logic [OP_W*N_REQ-1:0]  a_bi,
    input  logic [OP_W*N_REQ-1:0]  b_bi,
    output logic [N_REQ-1:0]       gnt_o,
    output logic                   done_o,
    output logic [ID_W-1:0]        done_id_o,
    output logic [OP_W-1:0]        y_bo,
    output logic                   err_o,
    output logic                   busy_o,
    output logic                   fun_start_o,
    output logic [OP_W-1:0]        fun_a_bo,
    output logic [OP_W-1:0]        fun_b_bo,
    input  logic                   fun_busy_i,
    input  logic [OP_W-1:0]        fun_y_bi
);

    state_t             state;
    state_t             state_next;
    logic [ID_W-1:0]    ptr;
    logic [ID_W-1:0]    id_q;
    logic [N_REQ-1:0]   arb_gnt;
    logic [ID_W-1:0]    arb_idx;
    logic               arb_any;
    logic               grant_take;
    logic               enter_done;
    logic               timeout;
    logic [OP_W-1:0]    a_arr [N_REQ];
    logic [OP_W-1:0]    b_arr [N_REQ];

    for (genvar k = 0; k < N_REQ; k++) begin : g_unpack
        assign a_arr[k] = a_bi[k*OP_W +: OP_W];
        assign b_arr[k] = b_bi[k*OP_W +: OP_W];
    end

    rr_arbiter #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_arb (
        .req (req_i),
        .ptr (ptr),
        .gnt (arb_gnt),
        .idx (arb_idx),
        .any (arb_any)
    );

    assign busy_o = (state != ST_IDLE);

    // State register.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) state <= ST_IDLE;
        else        state <= state_next;
    end

    // Next-state logic plus the grant/complete strobes for the datapath.
    always_comb begin
        state_next = state;
        grant_take = 1'b0;
        enter_done = 1'b0;
        case (state)
            ST_IDLE: begin
                if (arb_any) begin
                    state_next = ST_ISSUE;
                    grant_take = 1'b1;
                end
            end
            ST_ISSUE: state_next = ST_ACK;
            ST_ACK: begin
                if (timeout) begin
                    state_next = ST_DONE;
                    enter_done = 1'b1;
                end else if (fun_busy_i) begin
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (timeout || !fun_busy_i) begin
                    state_next = ST_DONE;
                    enter_done = 1'b1;
                end
            end
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // Grant, operand/id latching, start pulse and result capture.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            ptr         <= '0;
            id_q        <= '0;
            gnt_o       <= '0;
            done_o      <= 1'b0;
            done_id_o   <= '0;
            y_bo        <= '0;
            fun_start_o <= 1'b0;
            fun_a_bo    <= '0;
            fun_b_bo    <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples the pre-edge values and updates together.
            gnt_o       <= '0;
            done_o      <= 1'b0;
            fun_start_o <= (state == ST_ISSUE);
            if (grant_take) begin
                gnt_o    <= arb_gnt;
                fun_a_bo <= a_arr[arb_idx];
                fun_b_bo <= b_arr[arb_idx];
                id_q     <= arb_idx;
                ptr      <= ID_W'(wrap_inc(int'(arb_idx), N_REQ));
            end
            if (enter_done) begin
                done_o    <= 1'b1;
                done_id_o <= id_q;
                y_bo      <= timeout ? '0 : fun_y_bi;
            end
        end
    end

`ifdef FUN_SCHED_WATCHDOG_EN
    localparam int WD_W = $clog2(TIMEOUT + 1);
    logic [WD_W-1:0] wd_cnt;

    assign timeout = ((state == ST_ACK) || (state == ST_RUN)) && (wd_cnt == WD_W'(TIMEOUT));

    // Cycle counter for ACK/RUN; restarts from zero on every state change.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i)                   wd_cnt <= '0;
        else if (state_next != state) wd_cnt <= '0;
        else if (((state == ST_ACK) || (state == ST_RUN)) && !timeout)
                                      wd_cnt <= wd_cnt + 1'b1;
    end

    // Error flag travels with done_o and holds until the next result.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i)          err_o <= 1'b0;
        else if (enter_done) err_o <= timeout;
    end
`else
    assign timeout = 1'b0;
    assign err_o   = 1'b0;
`endif

endmodule

// File: tb/tb_fun_sched.sv
// Scoreboard bench for fun_sched: a behavioural fun unit answers the start
// handshake, a grant monitor predicts the winner and result, and a done
// monitor compares every returned result against the queued prediction.
module tb_fun_sched;

    localparam int N = 4;

    logic           clk_i = 1'b0;
    logic           rst_i = 1'b0;
    logic [N-1:0]   req_i = '0;
    logic [8*N-1:0] a_bi  = '0;
    logic [8*N-1:0] b_bi  = '0;
    logic [N-1:0]   gnt_o;
    logic           done_o;
    logic [1:0]     done_id_o;
    logic [7:0]     y_bo;
    logic           err_o;
    logic           busy_o;
    logic           fun_start_o;
    logic [7:0]     fun_a_bo;
    logic [7:0]     fun_b_bo;
    logic           fun_busy_i = 1'b0;
    logic [7:0]     fun_y_bi   = '0;

    fun_sched #(.N_REQ(N), .ID_W(2), .TIMEOUT(255)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .req_i       (req_i),
        .a_bi        (a_bi),
        .b_bi        (b_bi),
        .gnt_o       (gnt_o),
        .done_o      (done_o),
        .done_id_o   (done_id_o),
        .y_bo        (y_bo),
        .err_o       (err_o),
        .busy_o      (busy_o),
        .fun_start_o (fun_start_o),
        .fun_a_bo    (fun_a_bo),
        .fun_b_bo    (fun_b_bo),
        .fun_busy_i  (fun_busy_i),
        .fun_y_bi    (fun_y_bi)
    );

    always #5 clk_i = ~clk_i;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    always @(posedge clk_i) cyc++;

    typedef struct {
        int id;
        int y;
        int gcyc;
    } exp_t;

    exp_t sb_q[$];
    int   lat_q[$];
    int   grant_cnt = 0;
    int   start_cnt = 0;
    int   done_cnt  = 0;
    int   force_lat = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int isqrt(input int x);
        int r = 0;
        while ((r + 1) * (r + 1) <= x) r++;
        return r;
    endfunction

    function automatic int icbrt(input int x);
        int r = 0;
        while ((r + 1) * (r + 1) * (r + 1) <= x) r++;
        return r;
    endfunction

    function automatic int fun_ref(input int a, input int b);
        return isqrt(a + icbrt(b));
    endfunction

    // Behavioural fun unit: busy rises the cycle after start, stays high for
    // a random number of cycles, then the result appears as busy drops.
    bit         armed    = 1'b0;
    int         bcnt     = 0;
    int         next_lat = 1;
    logic [7:0] pend_y   = '0;
    always @(negedge clk_i) begin
        if (armed) begin
            armed      = 1'b0;
            fun_busy_i = 1'b1;
            bcnt       = next_lat;
            fun_y_bi   = 8'($urandom);
        end else if (bcnt > 0) begin
            bcnt--;
            if (bcnt == 0) begin
                fun_busy_i = 1'b0;
                fun_y_bi   = pend_y;
            end
        end
        if (rst_i && fun_start_o) begin
            next_lat = (force_lat > 0) ? force_lat : int'($urandom_range(1, 4));
            pend_y   = 8'(fun_ref(int'(fun_a_bo), int'(fun_b_bo)));
            armed    = 1'b1;
            lat_q.push_back(next_lat);
            start_cnt++;
        end
    end

    // Grant monitor: the winner is the first pending requester at or after
    // the model pointer, using the request/operands sampled before the edge.
    logic [N-1:0]   req_snap = '0;
    logic [8*N-1:0] a_snap   = '0;
    logic [8*N-1:0] b_snap   = '0;
    int             mptr     = 0;
    always @(negedge clk_i) begin
        int   win;
        exp_t e;
        if (!rst_i) begin
            mptr = 0;
        end else if (gnt_o != '0) begin
            win = -1;
            for (int i = 0; i < N; i++)
                if (win < 0 && req_snap[(mptr + i) % N]) win = (mptr + i) % N;
            check("grant_winner", 32'(gnt_o), (win < 0) ? 32'd0 : (32'd1 << win));
            if (win >= 0) begin
                e.id   = win;
                e.y    = fun_ref(int'(a_snap[win*8 +: 8]), int'(b_snap[win*8 +: 8]));
                e.gcyc = cyc;
                sb_q.push_back(e);
                mptr = (win + 1) % N;
            end
            grant_cnt++;
        end
        req_snap = req_i;
        a_snap   = a_bi;
        b_snap   = b_bi;
    end

    // Done monitor: pop the oldest prediction and compare.
    always @(negedge clk_i) begin
        exp_t e;
        int   l;
        if (rst_i && done_o) begin
            done_cnt++;
            if (sb_q.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                e = sb_q.pop_front();
                check("done_id", 32'(done_id_o), 32'(e.id));
                check("y", 32'(y_bo), 32'(e.y));
                check("err", 32'(err_o), 32'd0);
                if (lat_q.size() > 0) begin
                    l = lat_q.pop_front();
                    check("latency", 32'(cyc - e.gcyc), 32'(l + 3));
                end
            end
        end
    end

    // One stimulus step: inputs change 2 time units after the rising edge;
    // requesters drop their bit on their grant unless held by keep.
    task automatic cycle(input logic [N-1:0] keep);
        @(posedge clk_i);
        #2;
        req_i = req_i & ~(gnt_o & ~keep);
    endtask

    task automatic drain(input string name);
        int i;
        for (i = 0; i < 400; i++) begin
            cycle('0);
            if (req_i == '0 && !busy_o && sb_q.size() == 0) break;
        end
        check({name, "_drain"}, 32'(i < 400), 32'd1);
        repeat (3) cycle('0);
    endtask

    task automatic reset_checks(input string tag);
        check({tag, "_gnt"},     32'(gnt_o),       32'd0);
        check({tag, "_done"},    32'(done_o),      32'd0);
        check({tag, "_done_id"}, 32'(done_id_o),   32'd0);
        check({tag, "_y"},       32'(y_bo),        32'd0);
        check({tag, "_err"},     32'(err_o),       32'd0);
        check({tag, "_busy"},    32'(busy_o),      32'd0);
        check({tag, "_start"},   32'(fun_start_o), 32'd0);
        check({tag, "_fun_a"},   32'(fun_a_bo),    32'd0);
        check({tag, "_fun_b"},   32'(fun_b_bo),    32'd0);
    endtask

    task automatic set_ops(input int k, input logic [7:0] a, input logic [7:0] b);
        a_bi[k*8 +: 8] = a;
        b_bi[k*8 +: 8] = b;
    endtask

    initial begin
        int j;
        int i;
        int g0;
        logic [N-1:0] seen [2];

        #1 reset_checks("por");
        repeat (2) @(posedge clk_i);
        #2 rst_i = 1'b1;
        repeat (2) cycle('0);

        // Single request on requester 0: sqrt(9 + cbrt(27)) = 3.
        set_ops(0, 8'd9, 8'd27);
        req_i = 4'b0001;
        for (i = 0; i < 50 && gnt_o == '0; i++) begin
            @(posedge clk_i);
            #2;
        end
        check("t1_gnt", 32'(gnt_o), 32'd1);
        req_i = '0;
        drain("t1");
        check("t1_y", 32'(y_bo), 32'd3);

        // All four held with a=k, b=k^3; pointer now 1, so order is 1,2,3,0,1.
        for (int k = 0; k < N; k++) set_ops(k, 8'(k), 8'(k * k * k));
        req_i = 4'b1111;
        j = 0;
        for (i = 0; i < 500 && j < 5; i++) begin
            cycle(4'b1111);
            if (gnt_o != '0) begin
                check("t2_order", 32'(gnt_o), 32'd1 << ((1 + j) % N));
                j++;
                if (j == 5) req_i = '0;
            end
        end
        check("t2_count", 32'(j), 32'd5);
        drain("t2");

        // Pointer is 2: simultaneous 0101 grants requester 2 then 0.
        set_ops(0, 8'($urandom), 8'($urandom));
        set_ops(2, 8'($urandom), 8'($urandom));
        req_i = 4'b0101;
        j = 0;
        for (i = 0; i < 500 && j < 2; i++) begin
            @(posedge clk_i);
            #2;
            if (gnt_o != '0) begin
                seen[j] = gnt_o;
                j++;
            end
            // Drop the granted bit one cycle after its grant.
            @(posedge clk_i);
            #2;
            if (j > 0) req_i = req_i & ~seen[j-1];
        end
        check("t3_first", 32'(seen[0]), 32'd4);
        check("t3_second", 32'(seen[1]), 32'd1);
        drain("t3");
        g0 = grant_cnt;
        repeat (20) cycle('0);
        check("t3_no_extra_grant", 32'(grant_cnt), 32'(g0));

        // Random traffic: new requests carry fresh operands; sometimes a
        // requester keeps its line high after the grant.
        for (int c = 0; c < 300; c++) begin
            cycle(N'($urandom) & N'($urandom) & N'($urandom));
            for (int k = 0; k < N; k++) begin
                if (!req_i[k] && ($urandom % 4 == 0)) begin
                    set_ops(k, 8'($urandom), 8'($urandom));
                    req_i[k] = 1'b1;
                end
            end
        end
        drain("rand");

        // Reset while the unit is running aborts the operation.
        force_lat = 20;
        set_ops(3, 8'd50, 8'd125);
        req_i = 4'b1000;
        for (i = 0; i < 100 && !fun_busy_i; i++) cycle('0);
        check("t5_reached_run", 32'(fun_busy_i), 32'd1);
        repeat (3) cycle('0);
        #1 rst_i = 1'b0;
        #1 reset_checks("mid");
        sb_q.delete();
        lat_q.delete();
        req_i = '0;
        repeat (3) @(posedge clk_i);
        #2 rst_i = 1'b1;
        force_lat = 0;
        g0 = done_cnt;
        repeat (30) cycle('0);
        check("t5_no_done_after_abort", 32'(done_cnt), 32'(g0));
        for (int k = 0; k < N; k++) set_ops(k, 8'($urandom), 8'($urandom));
        req_i = 4'b1111;
        for (i = 0; i < 50 && gnt_o == '0; i++) begin
            @(posedge clk_i);
            #2;
        end
        check("t5_gnt_after_reset", 32'(gnt_o), 32'd1);
        req_i = '0;
        drain("t5");

        check("starts_vs_grants", 32'(start_cnt), 32'(grant_cnt));
        check("done_vs_grants", 32'(done_cnt), 32'(grant_cnt - 1));
        check("sb_empty", 32'(sb_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish in time");
        $fatal(1, "timeout");
    end

endmodule
